// File: rtl/id_match_stats_pkg.sv
// Shared types and default widths for the identifier-match statistics block.
package id_match_stats_pkg;

  localparam int CNT_W_DEF = 16;
  localparam int RUN_W_DEF = 8;

  localparam logic [CNT_W_DEF-1:0] CNT_MAX = '1;
  localparam logic [RUN_W_DEF-1:0] RUN_MAX = '1;

  // Two-bit encoding leaves spare codes that must recover to IDLE.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACK  = 2'd1
  } rd_state_e;

endpackage

// File: rtl/id_match_stats_sat_counter.sv
// Saturating up-counter with clear and load-one; nxt_o exposes the next value.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         load1_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o,
  output logic [W-1:0] nxt_o,
  output logic         sat_o
);

  localparam logic [W-1:0] MAX = '1;
  localparam logic [W-1:0] ONE = W'(1);

  logic [W-1:0] cnt_q, cnt_d;

  assign sat_o = (cnt_q == MAX);

  // Clear beats load-one, which beats increment.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (load1_i)
      cnt_d = ONE;
    else if (inc_i && !sat_o)
      cnt_d = cnt_q + ONE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;
  assign nxt_o = cnt_d;

endmodule

// File: rtl/id_match_stats.sv
// Match-event statistics (count, current/longest run, sticky overflow) with a
// snapshot read through a 4-phase rd_req/rd_ack handshake.
module id_match_stats
  import id_match_stats_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int RUN_W = RUN_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             match_in,
  input  logic             clr,
  input  logic             rd_req,
  output logic             rd_ack,
  output logic [CNT_W-1:0] id_count,
  output logic [RUN_W-1:0] cur_run,
  output logic [RUN_W-1:0] max_run,
  output logic             overflow,
  output logic [CNT_W-1:0] snap_count,
  output logic [RUN_W-1:0] snap_max,
  output logic             snap_ovf
);

  logic             match_q;
  logic             event_w, cont_w;
  logic             cnt_sat, run_sat;
  logic [CNT_W-1:0] cnt_nxt;
  logic [RUN_W-1:0] run_nxt;
  logic [RUN_W-1:0] max_q, max_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] snap_cnt_q;
  logic [RUN_W-1:0] snap_max_q;
  logic             snap_ovf_q;
  logic             capture;
  rd_state_e        state_q, state_d;

  assign event_w = match_in & ~match_q;
  assign cont_w  = match_in & match_q;

  sat_counter #(.W(CNT_W)) u_count (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (clr),
    .load1_i(1'b0),
    .inc_i  (event_w),
    .cnt_o  (id_count),
    .nxt_o  (cnt_nxt),
    .sat_o  (cnt_sat)
  );

  // A low match level ends the run, so it shares the counter's clear path.
  sat_counter #(.W(RUN_W)) u_run (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (clr | ~match_in),
    .load1_i(event_w),
    .inc_i  (cont_w),
    .cnt_o  (cur_run),
    .nxt_o  (run_nxt),
    .sat_o  (run_sat)
  );

  always_comb begin
    max_d = (run_nxt > max_q) ? run_nxt : max_q;
    ovf_d = ovf_q | (event_w & cnt_sat) | (cont_w & run_sat);
    if (clr) begin
      max_d = '0;
      ovf_d = 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    case (state_q)
      ST_IDLE: if (rd_req) begin
        state_d = ST_ACK;
        capture = 1'b1;
      end
      ST_ACK:  if (!rd_req) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Snapshots load from pre-edge live values, so a same-cycle clr is not seen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      match_q    <= 1'b0;
      max_q      <= '0;
      ovf_q      <= 1'b0;
      state_q    <= ST_IDLE;
      snap_cnt_q <= '0;
      snap_max_q <= '0;
      snap_ovf_q <= 1'b0;
    end else begin
      match_q <= match_in;
      max_q   <= max_d;
      ovf_q   <= ovf_d;
      state_q <= state_d;
      if (capture) begin
        snap_cnt_q <= id_count;
        snap_max_q <= max_q;
        snap_ovf_q <= ovf_q;
      end
    end
  end

  assign rd_ack     = (state_q == ST_ACK);
  assign max_run    = max_q;
  assign overflow   = ovf_q;
  assign snap_count = snap_cnt_q;
  assign snap_max   = snap_max_q;
  assign snap_ovf   = snap_ovf_q;

endmodule

// File: tb/tb_id_match_stats.sv
// Directed bench for id_match_stats with narrow counters so saturation is reachable.
module tb_id_match_stats;

  localparam int CW = 4;
  localparam int RW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          match_in, clr, rd_req;
  logic          rd_ack, overflow, snap_ovf;
  logic [CW-1:0] id_count, snap_count;
  logic [RW-1:0] cur_run, max_run, snap_max;

  int n_chk = 0;
  int n_err = 0;

  id_match_stats #(.CNT_W(CW), .RUN_W(RW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .match_in  (match_in),
    .clr       (clr),
    .rd_req    (rd_req),
    .rd_ack    (rd_ack),
    .id_count  (id_count),
    .cur_run   (cur_run),
    .max_run   (max_run),
    .overflow  (overflow),
    .snap_count(snap_count),
    .snap_max  (snap_max),
    .snap_ovf  (snap_ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic m, c, r;
    int   cnt, cur, mx, ovf, ack;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input int n);
    for (int k = 0; k < n; k++) begin
      match_in = 1'b1; step();
      match_in = 1'b0; step();
    end
  endtask

  task automatic do_clr();
    clr = 1'b1; step();
    clr = 1'b0;
  endtask

  initial begin
    tbl[0] = '{1'b0, 1'b0, 1'b0, 0, 0, 0, 0, 0};
    tbl[1] = '{1'b1, 1'b0, 1'b0, 1, 1, 1, 0, 0};
    tbl[2] = '{1'b1, 1'b0, 1'b0, 1, 2, 2, 0, 0};
    tbl[3] = '{1'b1, 1'b0, 1'b0, 1, 3, 3, 0, 0};
    tbl[4] = '{1'b0, 1'b0, 1'b0, 1, 0, 3, 0, 0};
    tbl[5] = '{1'b1, 1'b0, 1'b0, 2, 1, 3, 0, 0};
    tbl[6] = '{1'b0, 1'b0, 1'b0, 2, 0, 3, 0, 0};
    tbl[7] = '{1'b0, 1'b1, 1'b0, 0, 0, 0, 0, 0};

    rst_n = 1'b0; match_in = 1'b0; clr = 1'b0; rd_req = 1'b0;
    #12;
    chk("rst_count", id_count, 0);
    chk("rst_cur", cur_run, 0);
    chk("rst_max", max_run, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_ack", rd_ack, 0);
    chk("rst_snap", snap_count, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      match_in = tbl[i].m; clr = tbl[i].c; rd_req = tbl[i].r;
      step();
      chk($sformatf("vec%0d_count", i), id_count, tbl[i].cnt);
      chk($sformatf("vec%0d_cur", i), cur_run, tbl[i].cur);
      chk($sformatf("vec%0d_max", i), max_run, tbl[i].mx);
      chk($sformatf("vec%0d_ovf", i), overflow, tbl[i].ovf);
      chk($sformatf("vec%0d_ack", i), rd_ack, tbl[i].ack);
    end
    clr = 1'b0; match_in = 1'b0;

    // Run saturation: 20 cycles high with RUN_W=4.
    match_in = 1'b1;
    for (int i = 0; i < 15; i++) step();
    chk("run15_cur", cur_run, 15);
    chk("run15_ovf", overflow, 0);
    for (int i = 0; i < 5; i++) step();
    chk("runsat_cur", cur_run, 15);
    chk("runsat_max", max_run, 15);
    chk("runsat_ovf", overflow, 1);
    chk("runsat_count", id_count, 1);
    match_in = 1'b0; step();
    chk("rundrop_cur", cur_run, 0);
    chk("rundrop_max", max_run, 15);
    chk("rundrop_ovf", overflow, 1);
    do_clr();
    chk("runclr_ovf", overflow, 0);
    chk("runclr_max", max_run, 0);

    // Clear with the match level held high.
    match_in = 1'b1; step();
    chk("hold_pre_count", id_count, 1);
    clr = 1'b1; step();
    chk("hold_clr_count", id_count, 0);
    chk("hold_clr_cur", cur_run, 0);
    chk("hold_clr_max", max_run, 0);
    clr = 1'b0; step();
    chk("hold_post_count", id_count, 0);
    chk("hold_post_cur", cur_run, 1);
    chk("hold_post_max", max_run, 1);
    match_in = 1'b0; step();
    do_clr();

    // Handshake with statistics moving during ACK.
    match_in = 1'b1; step(); step(); step();
    match_in = 1'b0; step();
    pulse(4);
    chk("hs_pre_count", id_count, 5);
    chk("hs_pre_max", max_run, 3);
    rd_req = 1'b1; step();
    chk("hs_ack1", rd_ack, 1);
    chk("hs_snap_count", snap_count, 5);
    chk("hs_snap_max", snap_max, 3);
    pulse(2);
    chk("hs_live_count", id_count, 7);
    chk("hs_frozen_count", snap_count, 5);
    chk("hs_ack_held", rd_ack, 1);
    rd_req = 1'b0; step();
    chk("hs_ack_drop", rd_ack, 0);
    rd_req = 1'b1; step();
    chk("hs2_ack", rd_ack, 1);
    chk("hs2_snap_count", snap_count, 7);
    rd_req = 1'b0; step();
    chk("hs2_ack_drop", rd_ack, 0);

    // Clear and capture on the same edge.
    do_clr();
    pulse(9);
    chk("cc_pre_count", id_count, 9);
    clr = 1'b1; rd_req = 1'b1; step();
    chk("cc_snap_count", snap_count, 9);
    chk("cc_count", id_count, 0);
    chk("cc_ack", rd_ack, 1);
    clr = 1'b0; rd_req = 1'b0; step();
    chk("cc_ack_drop", rd_ack, 0);

    // Event-counter saturation with CNT_W=4.
    do_clr();
    pulse(15);
    chk("csat15_count", id_count, 15);
    chk("csat15_ovf", overflow, 0);
    pulse(1);
    chk("csat_count", id_count, 15);
    chk("csat_ovf", overflow, 1);
    rd_req = 1'b1; step();
    chk("csat_snap_ovf", snap_ovf, 1);
    chk("csat_snap_count", snap_count, 15);
    chk("csat_ack", rd_ack, 1);

    // Asynchronous reset in the middle of ACK.
    #3 rst_n = 1'b0;
    #1;
    chk("arst_ack", rd_ack, 0);
    chk("arst_count", id_count, 0);
    chk("arst_cur", cur_run, 0);
    chk("arst_max", max_run, 0);
    chk("arst_ovf", overflow, 0);
    chk("arst_snap_count", snap_count, 0);
    chk("arst_snap_max", snap_max, 0);
    chk("arst_snap_ovf", snap_ovf, 0);
    rd_req = 1'b0;
    #1 rst_n = 1'b1;
    step();
    chk("arst_idle_ack", rd_ack, 0);
    rd_req = 1'b1; step();
    chk("arst_reack", rd_ack, 1);
    rd_req = 1'b0; step();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/id_match_stats.md
Name: id_match_stats

Overview:
- Downstream consumer of the identifier recognizer's registered match flag (`out`).
- Counts identifier match events, tracks current and longest consecutive-match runs, and exposes a snapshot of the statistics through a 4-phase request/acknowledge read handshake.
- Sits between the recognizer and the host/test logic that reads statistics.

Parameters:
- CNT_W, 16, width of the match-event counter and its snapshot.
- RUN_W, 8, width of the run-length counters and their snapshots.

Ports:
- clk  input  1  rising-edge clock, same clock as the recognizer.
- rst_n  input  1  asynchronous active-low reset.
- match_in  input  1  recognizer match flag, sampled every posedge.
- clr  input  1  synchronous clear of live statistics.
- rd_req  input  1  snapshot request, 4-phase level handshake.
- rd_ack  output  1  snapshot valid / acknowledge.
- id_count  output  CNT_W  live count of match events.
- cur_run  output  RUN_W  live length of the current match run.
- max_run  output  RUN_W  live longest run since reset/clear.
- overflow  output  1  sticky saturation flag.
- snap_count  output  CNT_W  captured id_count.
- snap_max  output  RUN_W  captured max_run.
- snap_ovf  output  1  captured overflow.

Behaviour:
- Reset (rst_n=0, asynchronous): all outputs 0, match_q=0, FSM=IDLE. Effect is immediate, including mid-handshake; rd_ack drops at once.
- match_q is the registered copy of match_in. A match event occurs when match_in=1 and match_q=0 at a posedge.
- id_count:
  - +1 on each event; saturates at 2^CNT_W-1.
  - An event while saturated sets overflow.
- cur_run:
  - Event cycle: becomes 1.
  - match_in=1 and match_q=1: +1, saturating at 2^RUN_W-1.
  - match_in=0: becomes 0.
  - Saturation of cur_run with match_in still high sets overflow.
- max_run:
  - Updated every cycle to max(max_run, next cur_run).
  - It therefore tracks the running value, not only completed runs.
- Latency: every live output reflects match_in sampled at posedge N after posedge N (one-cycle register latency). No combinational path from inputs to outputs.
- overflow: sticky; cleared only by reset or clr.
- clr=1 at a posedge:
  - id_count, cur_run, max_run, overflow become 0.
  - match_q still loads match_in, so a level held high across clr is not recounted as an event.
  - clr wins over a simultaneous event or increment.
  - Snapshot registers are not affected by clr.
- Read FSM, states IDLE and ACK:
  - IDLE, rd_req=1: load snap_* from the live values as they were before this edge's update; go to ACK; rd_ack=1 next cycle.
  - ACK: hold rd_ack=1 and snap_* stable while rd_req=1.
  - ACK, rd_req=0: go to IDLE; rd_ack=0 next cycle.
  - A new capture requires rd_req low for at least one IDLE sample.
- clr and capture in the same cycle: the snapshot holds the pre-clear values.
- Statistics keep updating during ACK; only snap_* are frozen.
- Unused FSM encodings return to IDLE.

Decomposition:
- Shared package holds:
  - FSM state enum (IDLE, ACK).
  - Default widths CNT_W/RUN_W.
  - Localparams CNT_MAX/RUN_MAX as all-ones.
- One natural sub-module: sat_counter (parameterised width; inc, load-1, clr; saturated output). Instantiated for id_count and cur_run.
- Read FSM and max tracking stay in the top module.

Test Plan:
- Reset: rst_n=0 mid-ACK → rd_ack, id_count, cur_run, max_run, overflow, snap_* all 0 immediately; FSM IDLE after release.
- Pattern: match_in 0,1,1,1,0,1,0 (one value per cycle) → id_count ends at 2; cur_run sequence 0,1,2,3,0,1,0; max_run ends at 3.
- Saturation: RUN_W=4, hold match_in=1 for 20 cycles → cur_run stops at 15; max_run=15; overflow=1 and stays 1 after match_in drops, until clr.
- Clear with level held high: match_in held 1 across clr pulse → counts zeroed; no new event (id_count stays 0); cur_run restarts counting from 1 next cycle.
- Handshake: id_count=5, max_run=3; raise rd_req → rd_ack=1 next cycle, snap_count=5, snap_max=3.
  - 2 more events during ACK → snap_count still 5.
  - Drop rd_req → rd_ack=0 next cycle.
  - A second rd_req captures 7.
- Clear and capture together: clr and rd_req rising in the same cycle with id_count=9 → snap_count=9, id_count=0.
